latch_write_ctrl: RTL

LATCH_WRITE_CTRL -- requirements
Module: latch_write_ctrl

---
 rtl/latch_write_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/latch_write_ctrl.sv
// Write sequencer for an external latch bank: set up LD, pulse LEN, hold, then
// read back true/complement outputs and flag a mismatch.
module latch_write_ctrl #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 3,
  parameter int HOLD_CYC  = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_ld,
  output logic             o_len,
  input  logic [WIDTH-1:0] i_lq,
  input  logic [WIDTH-1:0] i_lqn,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [7:0]       o_err_cnt
);

  // state | meaning
  // IDLE  | waiting for START, LD held from last write
  // SETUP | LD stable, LEN low, SETUP_CYC cycles
  // PULSE | LEN high, PULSE_CYC cycles
  // HOLD  | LD stable after LEN falls, HOLD_CYC cycles
  // CHECK | one cycle; read back compared at exit edge
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_CHECK
  } state_t;

  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_ld;
  logic             r_len;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [7:0]       r_err_cnt;
  logic             w_err;

  assign w_err = (i_lq != r_ld) || (i_lqn != ~i_lq);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_ld      <= '0;
      r_len     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_ld    <= i_din;
            r_cnt   <= SETUP_LD;
            r_busy  <= 1'b1;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_cnt == 4'd0) begin
            r_cnt   <= PULSE_LD;
            r_len   <= 1'b1;
            r_state <= S_PULSE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_PULSE: begin
          if (r_cnt == 4'd0) begin
            r_cnt   <= HOLD_LD;
            r_len   <= 1'b0;
            r_state <= S_HOLD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_HOLD: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_CHECK;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_CHECK: begin
          r_err   <= w_err;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
          // error counter saturates rather than wrapping
          if (w_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
          end
        end
        default: begin
          r_len   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ld      = r_ld;
  assign o_len     = r_len;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_err     = r_err;
  assign o_err_cnt = r_err_cnt;

endmodule
